// File: rtl/flash_fill_ctrl.sv
// rtl/flash_fill_ctrl.sv - SPI line-fill sequencer between sram_ctrl and the serial flash
//
// On a read miss this block issues one SPI READ for the whole cache line,
// assembles the returned bits into DATA_W-bit words, strobes each word into
// the SRAM line buffer and pulses fill_done when the line is complete.
// It is the only master of the flash pins.
//
// Build option: define FAST_READ_EN to use opcode 0x0B followed by 8 dummy
// sck cycles; left undefined, opcode 0x03 is used with no dummy phase.
//
// Ports:
//   clk        system clock, everything on the rising edge
//   rst        synchronous active-high reset
//   miss_req   line fill request from sram_ctrl (level, sampled in IDLE)
//   miss_addr  byte address of the missing access
//   busy       fill in progress (accept through DONE)
//   fill_done  one-cycle pulse when the line has been written
//   ram_we     one-cycle SRAM write strobe per word
//   ram_addr   word index within the line
//   ram_wdata  assembled word, held until the next word
//   flash_cs   chip select, active low
//   flash_sck  SPI clock, mode 0 (idles low)
//   flash_si   serial data to flash
//   flash_so   serial data from flash

module flash_fill_ctrl #(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 8,
  parameter int CLK_DIV    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          miss_req,
  input  logic [ADDR_W-1:0]             miss_addr,
  output logic                          busy,
  output logic                          fill_done,
  output logic                          ram_we,
  output logic [$clog2(LINE_WORDS)-1:0] ram_addr,
  output logic [DATA_W-1:0]             ram_wdata,
  output logic                          flash_cs,
  output logic                          flash_sck,
  output logic                          flash_si,
  input  logic                          flash_so
);

  localparam int WORD_AW = $clog2(LINE_WORDS);
  localparam int OFF_W   = $clog2(LINE_WORDS * DATA_W / 8);
  // One counter serves the 8-bit opcode, 24-bit address, dummy and word phases.
  localparam int CNT_W   = ($clog2(DATA_W) > 5) ? $clog2(DATA_W) : 5;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]   DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]   CMD_LAST  = CNT_W'(7);
  localparam logic [CNT_W-1:0]   ADDR_LAST = CNT_W'(23);
  localparam logic [CNT_W-1:0]   DUM_LAST  = CNT_W'(7);
  localparam logic [WORD_AW-1:0] WORD_LAST = WORD_AW'(LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0]  OFF_MASK  = ADDR_W'((64'd1 << OFF_W) - 64'd1);

`ifdef FAST_READ_EN
  localparam logic [7:0] OPCODE = 8'h0B;
`else
  localparam logic [7:0] OPCODE = 8'h03;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_DATA,
    S_DONE
  } state_t;

  state_t               state_q;
  logic [DIV_W-1:0]     div_q;
  logic [CNT_W-1:0]     bit_cnt_q;
  logic [WORD_AW-1:0]   word_cnt_q;
  logic [31:0]          tx_q;
  logic [DATA_W-2:0]    rx_q;
  logic                 last_q;
  logic                 busy_q;
  logic                 fill_done_q;
  logic                 ram_we_q;
  logic [WORD_AW-1:0]   ram_addr_q;
  logic [DATA_W-1:0]    ram_wdata_q;
  logic                 cs_q;
  logic                 sck_q;
  logic                 si_q;

  logic [ADDR_W-1:0]    line_addr;
  logic [23:0]          addr24;
  logic [31:0]          tx_init;

  assign line_addr = miss_addr & ~OFF_MASK;

  // The SPI address phase is always 24 bits wide.
  generate
    if (ADDR_W >= 24) begin : g_addr_trunc
      assign addr24 = line_addr[23:0];
    end else begin : g_addr_ext
      assign addr24 = {{(24 - ADDR_W){1'b0}}, line_addr};
    end
  endgenerate

  assign tx_init = {OPCODE, addr24};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      bit_cnt_q   <= '0;
      word_cnt_q  <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      fill_done_q <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      cs_q        <= 1'b1;
      sck_q       <= 1'b0;
      si_q        <= 1'b0;
    end else begin
      ram_we_q    <= 1'b0;
      fill_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (miss_req) begin
            state_q    <= S_CMD;
            busy_q     <= 1'b1;
            cs_q       <= 1'b0;
            sck_q      <= 1'b0;
            // First bit goes out with cs; the rest wait in the shifter.
            si_q       <= tx_init[31];
            tx_q       <= tx_init << 1;
            div_q      <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            last_q     <= 1'b0;
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          if (div_q != DIV_LAST) begin
            div_q <= div_q + DIV_W'(1);
          end else begin
            div_q <= '0;
            sck_q <= ~sck_q;
            if (!sck_q) begin
              // Edge driving sck high: flash data is sampled here.
              if (state_q == S_DATA) begin
                rx_q <= {rx_q[DATA_W-3:0], flash_so};
                if (bit_cnt_q == DATA_LAST) begin
                  bit_cnt_q   <= '0;
                  ram_we_q    <= 1'b1;
                  ram_addr_q  <= word_cnt_q;
                  ram_wdata_q <= {rx_q, flash_so};
                  if (word_cnt_q == WORD_LAST) begin
                    last_q <= 1'b1;
                  end else begin
                    word_cnt_q <= word_cnt_q + WORD_AW'(1);
                  end
                end else begin
                  bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                end
              end
            end else begin
              // Edge driving sck low: si advances, phases change here.
              case (state_q)
                S_CMD: begin
                  si_q <= tx_q[31];
                  tx_q <= tx_q << 1;
                  if (bit_cnt_q == CMD_LAST) begin
                    state_q   <= S_ADDR;
                    bit_cnt_q <= '0;
                  end else begin
                    bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                  end
                end
                S_ADDR: begin
                  if (bit_cnt_q == ADDR_LAST) begin
                    si_q      <= 1'b0;
                    bit_cnt_q <= '0;
`ifdef FAST_READ_EN
                    state_q   <= S_DUMMY;
`else
                    state_q   <= S_DATA;
`endif
                  end else begin
                    si_q      <= tx_q[31];
                    tx_q      <= tx_q << 1;
                    bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                  end
                end
                S_DUMMY: begin
                  if (bit_cnt_q == DUM_LAST) begin
                    state_q   <= S_DATA;
                    bit_cnt_q <= '0;
                  end else begin
                    bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                  end
                end
                S_DATA: begin
                  // Finish the high half of the last bit before releasing cs.
                  if (last_q) begin
                    state_q     <= S_DONE;
                    cs_q        <= 1'b1;
                    sck_q       <= 1'b0;
                    fill_done_q <= 1'b1;
                  end
                end
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign fill_done = fill_done_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign flash_cs  = cs_q;
  assign flash_sck = sck_q;
  assign flash_si  = si_q;

endmodule

// File: tb/tb_flash_fill_ctrl.sv
// tb/tb_flash_fill_ctrl.sv - scoreboard bench for flash_fill_ctrl with a behavioural SPI flash

module tb_flash_fill_ctrl;

  localparam int ADDR_W     = 24;
  localparam int DATA_W     = 32;
  localparam int LINE_WORDS = 2;
  localparam int CLK_DIV    = 3;
  localparam int LINE_BYTES = LINE_WORDS * DATA_W / 8;
  localparam int WORD_BYTES = DATA_W / 8;
`ifdef FAST_READ_EN
  localparam int         HDR_BITS  = 40;
  localparam logic [7:0] OPC       = 8'h0B;
  localparam int         DUMMY_CYC = 16 * CLK_DIV;
`else
  localparam int         HDR_BITS  = 32;
  localparam logic [7:0] OPC       = 8'h03;
  localparam int         DUMMY_CYC = 0;
`endif
  localparam int LAT_BOUND = 2 * CLK_DIV * (32 + LINE_WORDS * DATA_W) + 4 + DUMMY_CYC;

  logic                          clk = 1'b0;
  logic                          rst = 1'b1;
  logic                          miss_req = 1'b0;
  logic [ADDR_W-1:0]             miss_addr = '0;
  logic                          busy;
  logic                          fill_done;
  logic                          ram_we;
  logic [$clog2(LINE_WORDS)-1:0] ram_addr;
  logic [DATA_W-1:0]             ram_wdata;
  logic                          flash_cs;
  logic                          flash_sck;
  logic                          flash_si;
  logic                          flash_so = 1'b0;

  always #5 clk = ~clk;

  flash_fill_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(LINE_WORDS), .CLK_DIV(CLK_DIV)
  ) dut (
    .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
    .busy(busy), .fill_done(fill_done), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .flash_cs(flash_cs), .flash_sck(flash_sck),
    .flash_si(flash_si), .flash_so(flash_so)
  );

  typedef struct {
    int                idx;
    logic [DATA_W-1:0] data;
  } wr_t;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  mem [int];
  logic [31:0] hdr_q [$];
  wr_t         wr_q [$];
  int          done_q [$];
  bit          expect_b2b = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] mem_byte(input int a);
    int m;
    m = a & 32'h00FF_FFFF;
    if (mem.exists(m)) return mem[m];
    return 8'((m * 37) ^ (m >> 3));
  endfunction

  // Reference model: a line read returns LINE_BYTES consecutive flash bytes
  // from the aligned line address, packed big-endian into words.
  task automatic push_expect(input logic [23:0] a);
    int                line;
    logic [DATA_W-1:0] w;
    wr_t               e;
    line = int'(a) & ~(LINE_BYTES - 1);
    hdr_q.push_back({OPC, 24'(line)});
    for (int wi = 0; wi < LINE_WORDS; wi++) begin
      w = '0;
      for (int b = 0; b < WORD_BYTES; b++)
        w = {w[DATA_W-9:0], mem_byte(line + wi * WORD_BYTES + b)};
      e.idx  = wi;
      e.data = w;
      wr_q.push_back(e);
    end
    done_q.push_back(1);
  endtask

  task automatic seed_line(input logic [23:0] a);
    int line;
    line = int'(a) & ~(LINE_BYTES - 1);
    for (int b = 0; b < LINE_BYTES; b++)
      if (!mem.exists(line + b)) mem[line + b] = 8'($urandom);
  endtask

  // ---------------- monitor + flash device model ----------------
  int          cyc = 0;
  int          run = 0;
  int          rises = 0;
  int          gap = 100;
  int          start_cyc = 0;
  int          wr_in_fill = 0;
  bit          prev_cs = 1;
  bit          prev_sck = 0;
  logic [31:0] hdr = '0;
  logic [23:0] dev_addr = '0;

  always @(negedge clk) begin
    logic [31:0] eh;
    wr_t         ew;
    logic [7:0]  bv;
    int          k;
    cyc++;
    if (!rst) begin
      if (prev_cs && !flash_cs) begin
        if (expect_b2b) check("cs_gap_b2b", gap, 2);
        else check("cs_gap_min", gap >= 2, 1);
        expect_b2b = 0;
        gap        = 0;
        start_cyc  = cyc;
        rises      = 0;
        wr_in_fill = 0;
        run        = 1;
        hdr        = '0;
        check("sck_low_at_cs_fall", flash_sck, 0);
      end else if (!prev_cs && !flash_cs) begin
        if (flash_sck != prev_sck) begin
          check("sck_half_period", run, CLK_DIV);
          run = 1;
          if (flash_sck) begin
            rises++;
            if (rises <= 32) hdr = {hdr[30:0], flash_si};
            if (rises == 32) begin
              dev_addr = hdr[23:0];
              if (hdr_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_fill: header %08h with no request", hdr);
              end else begin
                eh = hdr_q.pop_front();
                check("si_header", hdr, eh);
              end
            end
            if (rises > 32 && rises <= HDR_BITS) check("si_dummy_zero", flash_si, 0);
          end else begin
            // Mode 0 device: next output bit appears after sck falls.
            if (rises >= HDR_BITS) begin
              k  = rises - HDR_BITS;
              bv = mem_byte(int'(dev_addr) + k / 8);
              flash_so = bv[7 - (k % 8)];
            end else begin
              flash_so = 1'($urandom);
            end
          end
        end else begin
          run++;
        end
      end else if (!prev_cs && flash_cs) begin
        check("sck_last_high", run, CLK_DIV);
        check("sck_low_at_cs_rise", flash_sck, 0);
      end

      if (ram_we) begin
        wr_in_fill++;
        if (wr_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_write: addr %0d data %08h with none pending", ram_addr, ram_wdata);
        end else begin
          ew = wr_q.pop_front();
          check("ram_addr", ram_addr, ew.idx);
          check("ram_wdata", ram_wdata, ew.data);
        end
      end

      if (fill_done) begin
        if (done_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_done: fill_done=1 with no fill pending");
        end else begin
          void'(done_q.pop_front());
          check("latency_bound", (cyc - start_cyc + 1) <= LAT_BOUND, 1);
          check("words_per_line", wr_in_fill, LINE_WORDS);
          check("cs_high_at_done", flash_cs, 1);
          check("busy_at_done", busy, 1);
        end
      end
    end
    if (flash_cs) gap++;
    prev_cs  = flash_cs;
    prev_sck = flash_sck;
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < LAT_BOUND + 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      n_checks++;
      n_errors++;
      $display("FAIL idle_timeout: busy=%0b, expected 0", busy);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fill_done && n < LAT_BOUND + 20);
    if (!fill_done) begin
      n_checks++;
      n_errors++;
      $display("FAIL fill_timeout: no fill_done after %0d cycles, expected within %0d", n, LAT_BOUND);
    end
  endtask

  task automatic issue(input logic [23:0] a, input bit hold);
    seed_line(a);
    wait_idle();
    miss_req  = 1'b1;
    miss_addr = a;
    push_expect(a);
    if (!hold) begin
      @(negedge clk);
      miss_req = 1'b0;
    end
  endtask

  task automatic toggle_busy();
    repeat (40) begin
      @(negedge clk);
      miss_req  = 1'($urandom_range(0, 1));
      miss_addr = 24'h000400;
    end
    @(negedge clk);
    miss_req = 1'b0;
  endtask

  task automatic b2b(input logic [23:0] a, input logic [23:0] b);
    seed_line(b);
    issue(a, 1'b1);
    wait_done();
    miss_addr = b;
    push_expect(b);
    expect_b2b = 1;
    wait_done();
    miss_req = 1'b0;
  endtask

  initial begin
    #(10 * 80000);
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] line0 [8];
    line0 = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
    for (int i = 0; i < 8; i++) mem[32'h120 + i] = line0[i];

    repeat (3) @(negedge clk);
    check("rst_cs", flash_cs, 1);
    check("rst_sck", flash_sck, 0);
    check("rst_si", flash_si, 0);
    check("rst_busy", busy, 0);
    check("rst_fill_done", fill_done, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    rst = 1'b0;

    // Known line: words DEADBEEF then 01234567 from address 0x000120.
    issue(24'h000123, 1'b0);
    wait_done();

    // Requests while busy must not disturb the current fill.
    issue(24'h00A5C7, 1'b0);
    toggle_busy();
    wait_done();

    // Held request: second fill follows with exactly two cs-high cycles.
    b2b(24'h012345, 24'h0FFFF8);

    // Reset mid-fill, with a request colliding with reset.
    issue(24'h3456AB, 1'b0);
    repeat (60) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    hdr_q.delete();
    wr_q.delete();
    done_q.delete();
    check("abort_cs_next_edge", flash_cs, 1);
    check("abort_sck_next_edge", flash_sck, 0);
    miss_req  = 1'b1;
    miss_addr = 24'h000777;
    @(negedge clk);
    @(negedge clk);
    rst      = 1'b0;
    miss_req = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_cs", flash_cs, 1);
    check("abort_sck", flash_sck, 0);
    repeat (300) @(negedge clk);
    check("abort_still_idle", busy, 0);

    // Randomised fills.
    for (int i = 0; i < 10; i++) begin
      logic [23:0] a;
      logic [23:0] b;
      a = 24'($urandom);
      b = 24'($urandom);
      case ($urandom_range(0, 3))
        0: begin issue(a, 1'b0); wait_done(); end
        1: begin issue(a, 1'b0); toggle_busy(); wait_done(); end
        2: b2b(a, b);
        default: begin
          repeat ($urandom_range(0, 10)) @(negedge clk);
          issue(a, 1'b0);
          wait_done();
        end
      endcase
    end

    repeat (30) @(negedge clk);
    check("hdr_queue_empty", hdr_q.size(), 0);
    check("wr_queue_empty", wr_q.size(), 0);
    check("done_queue_empty", done_q.size(), 0);
    check("final_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
